// File: rtl/sensor_debounce_if.sv
// Raw field-sensor inputs and their conditioned outputs for the irrigation controller.
// The debouncer takes the slave side; whatever drives the raw lines takes the master side.
interface sensor_debounce_if;
    logic Us_raw;
    logic Bs_raw;
    logic Vs_raw;
    logic Adub_raw;
    logic Us;
    logic Bs;
    logic Vs;
    logic Adub;
    logic Adub_pulse;
    logic Fault;
    logic Valid;

    modport master (
        output Us_raw, Bs_raw, Vs_raw, Adub_raw,
        input  Us, Bs, Vs, Adub, Adub_pulse, Fault, Valid
    );

    modport slave (
        input  Us_raw, Bs_raw, Vs_raw, Adub_raw,
        output Us, Bs, Vs, Adub, Adub_pulse, Fault, Valid
    );
endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus per-channel debounce for the four irrigation sensor inputs,
// with startup settling, a fertilizer-button pulse and a tank-sensor consistency fault.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned FAULT_CYCLES    = 100000
) (
    input logic              Clk,
    input logic              Rst,
    sensor_debounce_if.slave bus
);
    localparam int unsigned       CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned       FltW    = $clog2(FAULT_CYCLES) + 1;
    localparam logic [CntW-1:0]   DbLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FltW-1:0]   FltLast = FltW'(FAULT_CYCLES - 1);
    localparam logic [FltW-1:0]   FltMax  = FltW'(FAULT_CYCLES);

    // Channel bit order: 0 = Us, 1 = Bs, 2 = Vs, 3 = Adub
    logic [3:0]           raw;
    logic [3:0]           sync1_q, sync2_q;
    logic [3:0]           level_q, level_d;
    logic [3:0][CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0]      startup_cnt_q, startup_cnt_d;
    logic [FltW-1:0]      fault_cnt_q, fault_cnt_d;
    logic                 valid_q, valid_d;
    logic                 pulse_q, pulse_d;
    logic                 fault_q, fault_d;
    logic                 inconsistent;

    assign raw = {bus.Adub_raw, bus.Vs_raw, bus.Bs_raw, bus.Us_raw};

    always_comb begin
        level_d       = level_q;
        cnt_d         = cnt_q;
        startup_cnt_d = startup_cnt_q;
        valid_d       = valid_q;
        pulse_d       = 1'b0;

        if (!valid_q) begin
            // Settling: outputs held at 0, then loaded directly without a pulse.
            if (startup_cnt_q == DbLast) begin
                valid_d = 1'b1;
                level_d = sync2_q;
            end else begin
                startup_cnt_d = startup_cnt_q + 1'b1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == DbLast) begin
                        level_d[i] = sync2_q[i];
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
            pulse_d = level_d[3] & ~level_q[3];
        end
    end

    // Judged on the registered levels, so it lags a level change by one cycle.
    assign inconsistent = valid_q & level_q[2] & ~level_q[1];

    always_comb begin
        fault_cnt_d = '0;
        fault_d     = 1'b0;
        if (inconsistent) begin
            fault_cnt_d = (fault_cnt_q == FltMax) ? FltMax : fault_cnt_q + 1'b1;
            fault_d     = (fault_cnt_q >= FltLast);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            level_q       <= '0;
            cnt_q         <= '0;
            startup_cnt_q <= '0;
            fault_cnt_q   <= '0;
            valid_q       <= 1'b0;
            pulse_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            level_q       <= level_d;
            cnt_q         <= cnt_d;
            startup_cnt_q <= startup_cnt_d;
            fault_cnt_q   <= fault_cnt_d;
            valid_q       <= valid_d;
            pulse_q       <= pulse_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.Us         = level_q[0];
    assign bus.Bs         = level_q[1];
    assign bus.Vs         = level_q[2];
    assign bus.Adub       = level_q[3];
    assign bus.Adub_pulse = pulse_q;
    assign bus.Fault      = fault_q;
    assign bus.Valid      = valid_q;
endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: vector table, hand-written reset/fault sequence and random
// stimulus, all checked every cycle against a history-window reference model.
module tb_sensor_debounce;
    localparam int D       = 4;
    localparam int F       = 8;
    localparam int HistLen = 8192;

    logic Clk;
    logic Rst;
    sensor_debounce_if ifc();

    sensor_debounce #(
        .DEBOUNCE_CYCLES(D),
        .FAULT_CYCLES   (F)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(ifc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Model state; raw bit order {Adub, Vs, Bs, Us}. Index 0 is the reset edge.
    logic [3:0] samp   [HistLen];
    logic [3:0] lvlh   [HistLen];
    logic       validh [HistLen];
    int         m_e = 0;
    logic [3:0] m_lvl = '0;
    logic       m_valid = 1'b0;
    logic       m_pulse = 1'b0;
    logic       m_fault = 1'b0;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        int         n;
        logic [3:0] lvl;
        logic       valid;
        logic       pulse;
        logic       fault;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] raw, input int n,
                                input logic [3:0] lvl, input logic valid, input logic pulse,
                                input logic fault);
        vec_t v;
        v.rst = rst; v.raw = raw; v.n = n; v.lvl = lvl;
        v.valid = valid; v.pulse = pulse; v.fault = fault;
        return v;
    endfunction

    function automatic logic [6:0] dut_vec();
        return {ifc.Valid, ifc.Fault, ifc.Adub_pulse, ifc.Adub, ifc.Vs, ifc.Bs, ifc.Us};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {V,F,P,lvl}=%b required %b", name, got, exp);
        end
    endtask

    // Output flips when the last D synchronized samples all disagree with it;
    // Fault is set when the previous F registered states were all valid and inconsistent.
    task automatic model_edge(input logic rst_on, input logic [3:0] raw);
        logic [3:0] prev;
        logic       prev_valid;
        logic       flip;
        logic       all_bad;
        if (rst_on) begin
            m_e = 0; samp[0] = '0; m_lvl = '0; m_valid = 1'b0;
            m_pulse = 1'b0; m_fault = 1'b0; lvlh[0] = '0; validh[0] = 1'b0;
            return;
        end
        if (m_e >= HistLen - 1) begin
            $display("FAIL model_history: got index %0d required below %0d", m_e, HistLen - 1);
            $fatal(1, "model history exhausted");
        end
        m_e++;
        samp[m_e] = raw;
        prev = m_lvl;
        prev_valid = m_valid;
        if (!m_valid) begin
            if (m_e == D) begin
                m_valid = 1'b1;
                m_lvl = samp[m_e - 2];
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                flip = 1'b1;
                for (int k = m_e - D - 1; k <= m_e - 2; k++)
                    if (samp[k][c] == prev[c]) flip = 1'b0;
                if (flip) m_lvl[c] = samp[m_e - 2][c];
            end
        end
        m_pulse = prev_valid && m_lvl[3] && !prev[3];
        all_bad = (m_e >= F);
        if (all_bad)
            for (int k = 1; k <= F; k++)
                if (!(validh[m_e - k] && lvlh[m_e - k][2] && !lvlh[m_e - k][1])) all_bad = 1'b0;
        m_fault = all_bad;
        lvlh[m_e] = m_lvl;
        validh[m_e] = m_valid;
    endtask

    task automatic tick(input logic rst_on, input logic [3:0] raw);
        Rst = ~rst_on;
        ifc.Us_raw = raw[0];
        ifc.Bs_raw = raw[1];
        ifc.Vs_raw = raw[2];
        ifc.Adub_raw = raw[3];
        @(posedge Clk);
        model_edge(rst_on, raw);
        @(negedge Clk);
        check($sformatf("model@e%0d", m_e), dut_vec(), {m_valid, m_fault, m_pulse, m_lvl});
    endtask

    logic [3:0] r;

    initial begin
        Rst = 1'b0;
        ifc.Us_raw = 1'b0; ifc.Bs_raw = 1'b0; ifc.Vs_raw = 1'b0; ifc.Adub_raw = 1'b0;

        // Reset, startup, latency
        tbl.push_back(mk(1, 4'b0011, 2, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 3, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0010, 6, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 5, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0011, 1, 0, 0));
        // Glitch rejection: 3-cycle then 4-cycle low on Bs
        tbl.push_back(mk(0, 4'b0001, 3, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 6, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 4, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 3, 4'b0001, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0011, 1, 0, 0));
        // Button held 20 cycles, released, pressed again
        tbl.push_back(mk(0, 4'b1011, 5, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 1, 4'b1011, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1011, 1, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 13, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 5, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 4, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 5, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1011, 1, 4'b1011, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1011, 1, 4'b1011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 10, 4'b0011, 1, 0, 0));
        // Fault rises 8 edges after Vs=1/Bs=0 is debounced, falls one edge after Bs rises
        tbl.push_back(mk(0, 4'b0101, 5, 4'b0011, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0101, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 7, 4'b0101, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0101, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0101, 3, 4'b0101, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0111, 5, 4'b0101, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0111, 1, 4'b0111, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0111, 1, 4'b0111, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0111, 3, 4'b0111, 1, 0, 0));
        // Inconsistency lasting only 7 cycles
        tbl.push_back(mk(0, 4'b0101, 5, 4'b0111, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0101, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 1, 4'b0101, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0111, 4, 4'b0101, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0111, 1, 4'b0101, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0111, 1, 4'b0111, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0111, 8, 4'b0111, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++) tick(tbl[i].rst, tbl[i].raw);
            check($sformatf("vec%0d", i), dut_vec(),
                  {tbl[i].valid, tbl[i].fault, tbl[i].pulse, tbl[i].lvl});
        end

        // Reset while Fault=1 and a Us debounce is in flight; startup must repeat
        repeat (14) tick(1'b0, 4'b0101);
        check("mid_fault_set", {6'b0, ifc.Fault}, 7'b1);
        repeat (2) tick(1'b0, 4'b0100);
        tick(1'b1, 4'b0100);
        check("mid_reset_clear", dut_vec(), 7'b0000000);
        repeat (3) tick(1'b0, 4'b0100);
        check("restart_not_valid", dut_vec(), 7'b0000000);
        tick(1'b0, 4'b0100);
        check("restart_valid", dut_vec(), 7'b1000100);
        repeat (7) tick(1'b0, 4'b0100);
        check("restart_fault_pre", dut_vec(), 7'b1000100);
        tick(1'b0, 4'b0100);
        check("restart_fault_set", dut_vec(), 7'b1100100);

        // Random: glitchy Us/Adub, slower Bs/Vs so faults occur; one reset mid-run
        r = 4'b0000;
        tick(1'b1, r);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0)  r[0] = ~r[0];
            if ($urandom_range(19) == 0) r[1] = ~r[1];
            if ($urandom_range(19) == 0) r[2] = ~r[2];
            if ($urandom_range(5) == 0)  r[3] = ~r[3];
            tick(i == 1500, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sensor_debounce.md
# sensor_debounce

Input-conditioning stage that sits directly upstream of the irrigation top level. It takes the raw field inputs: soil-humidity switch, lower and upper tank-level sensors, and the fertilizer push-button. It synchronizes each one to `Clk`, debounces it, and delivers clean levels that replace the raw `Us`, `Bs`, `Vs`, `Adub` inputs of the irrigation logic. It also produces a fertilizer-request pulse, a tank-sensor consistency fault flag, and a valid flag that blocks downstream state machines from acting on unsettled inputs after reset.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a new synchronized level must persist before the output follows. Legal range ≥ 2.
- `FAULT_CYCLES`, default 100000: consecutive cycles of an inconsistent tank reading before `Fault` asserts. Legal range ≥ 2.
- `Clk`  in  1  system clock; the only clock.
- `Rst`  in  1  reset, synchronous, active-low.
- `Us_raw`  in  1  raw soil-humidity switch, asynchronous.
- `Bs_raw`  in  1  raw lower tank-level sensor; 1 = water above bottom.
- `Vs_raw`  in  1  raw upper tank-level sensor; 1 = water at top.
- `Adub_raw`  in  1  raw fertilizer button; 1 = pressed.
- `Us`, `Bs`, `Vs`, `Adub`  out  1 each  debounced levels.
- `Adub_pulse`  out  1  one-cycle pulse on each debounced rising edge of `Adub`.
- `Fault`  out  1  tank sensors inconsistent: `Vs`=1 while `Bs`=0.
- `Valid`  out  1  startup settling complete; outputs are meaningful.

## Operation
- **Reset** (`Rst`=0 at a rising edge): both synchronizer stages, the channel counters, the startup counter and the fault counter clear to 0. All outputs go to 0. Reset applies at any time, including mid-debounce or mid-fault; no state survives it.
- **Synchronizer:** every raw input passes through two flops, s1 then s2, before any logic uses it.
- **Startup:**
  - While `Valid`=0, a startup counter increments every cycle and all level outputs stay 0.
  - On the edge where the counter has completed `DEBOUNCE_CYCLES` cycles, each level output loads its s2 value directly, `Valid` sets to 1, and the counter stops.
  - `Valid` stays 1 until the next reset.
  - The startup load does not generate `Adub_pulse`.
- **Per-channel debounce** (four identical instances, active only when `Valid`=1):
  - On each edge, compare s2 with the output.
  - Mismatch: the counter increments. When the counter reaches `DEBOUNCE_CYCLES` and the mismatch is still present on that edge, the output takes the s2 value and the counter clears.
  - Match on any edge: the counter clears. A glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never reaches the output.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)+1`. It never wraps.
- **`Adub_pulse`:** high for exactly the one cycle after debounced `Adub` goes 0→1. No pulse on 1→0. Holding the button produces a single pulse.
- **Fault:**
  - Evaluated on the debounced outputs, only when `Valid`=1.
  - The fault counter increments each cycle `Vs & ~Bs` holds and clears on any cycle it does not hold.
  - `Fault` sets on the edge the counter reaches `FAULT_CYCLES`.
  - `Fault` clears on the first edge where the condition is false.
  - The counter saturates at `FAULT_CYCLES`.
  - `Fault` is informational only; it does not alter the level outputs.
- **Simultaneous events:** channels are fully independent. Several outputs may change on the same edge. `Fault` evaluation uses the registered outputs, so it sees a level change one cycle after that change appears.

## Timing
- **Output latency:** a raw change presented before edge n, and held, produces the output change after edge n+1+`DEBOUNCE_CYCLES`.
  - Edge n loads s1; edge n+1 loads s2; mismatch is then counted on `DEBOUNCE_CYCLES` edges.
- **`Adub_pulse`:** asserted the cycle after the edge where `Adub` rose; width exactly 1 cycle.
- **`Valid`:** rises after the `DEBOUNCE_CYCLES`-th edge following reset release.
- **`Fault`:** rises after `FAULT_CYCLES` consecutive inconsistent edges; falls after 1 consistent edge.
- **Throughput:** no handshake. Outputs are registered levels, updated every cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `FAULT_CYCLES`=8.
- **Reset and startup:** raw inputs = 1,1,0,0 (`Us`,`Bs`,`Vs`,`Adub`), release `Rst`. Required: all outputs 0 for 3 edges; after the 4th edge `Valid`=1, `Us`=1, `Bs`=1, `Vs`=0, `Adub`=0; `Adub_pulse` never asserts.
- **Latency:** with `Valid`=1, set `Us_raw` 0→1 before edge 1 and hold. Required: `Us` changes after edge 6, not after edge 5.
- **Glitch rejection:** pulse `Bs_raw` low for 3 cycles, then low again for 4 cycles. Required: the first pulse is ignored (`Bs` stays 1); the second drives `Bs`=0 for exactly 4 cycles.
- **Button:** hold `Adub_raw`=1 for 20 cycles, release, press again. Required: exactly two `Adub_pulse` cycles, each 1 cycle wide, each following a debounced rise.
- **Fault:**
  - Drive `Vs_raw`=1 and `Bs_raw`=0. Required: `Fault` rises 8 edges after the debounced condition first holds.
  - Set `Bs_raw`=1. Required: `Fault` falls the edge after `Bs` rises.
  - Repeat with the inconsistency lasting only 7 cycles. Required: no `Fault`.
- **Reset mid-operation:** assert `Rst`=0 for 1 edge mid-debounce with `Fault`=1. Required: all outputs 0 and `Valid`=0 on the next cycle; the full startup sequence repeats.
